// File: rtl/remap_packer.sv
// remap_packer: packs PACK consecutive M2 codes from the remap stage into one
// wide word. Valid/ready handshake on both sides: a beat transfers on any
// rising edge where valid && ready; the sender holds valid and its data
// stable until that edge. The output side is a single register stage. A flush
// pulse closes a partially filled word and tags it with out_last.
module remap_packer #(
    parameter int M2_W  = 15,
    parameter int PACK  = 4,
    parameter int CNT_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [M2_W-1:0]        in_m2,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [M2_W*PACK-1:0]   out_data,
    output logic [CNT_W-1:0]       out_cnt,
    output logic                   out_last
);

    localparam int                DATA_W    = M2_W * PACK;
    localparam int                LANE_W    = $clog2(PACK);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PACK - 1);

    // Input-side state: fill position, partial word, pending flush.
    logic [LANE_W-1:0] lane_q, lane_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              flush_pend_q, flush_pend_d;

    // Output register stage.
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
    logic              out_last_q, out_last_d;

    logic              slot_free;
    logic              accept;
    logic              completes;
    logic              flush_req;
    logic [CNT_W-1:0]  fill_cnt;
    logic [DATA_W-1:0] acc_merged;

    // The output slot can take a new word if it is empty or being drained now.
    assign slot_free = !out_valid_q || out_ready;

    // Only a word-completing code has to wait for the slot; everything else
    // lands in the accumulator. A pending flush blocks input until it drains.
    assign in_ready  = rst_n && !flush_pend_q && ((lane_q != LAST_LANE) || slot_free);
    assign accept    = in_valid && in_ready;
    assign completes = accept && (lane_q == LAST_LANE);

    // Lanes occupied once this cycle's code (if any) is counted.
    assign fill_cnt  = CNT_W'(lane_q) + CNT_W'(accept);

    // A flush only matters when there is something to emit; a pending flush
    // keeps requesting until the slot frees up.
    assign flush_req = flush_pend_q || (flush && (fill_cnt != '0));

    // Accumulator with the code accepted this cycle written into its lane.
    always_comb begin
        acc_merged = acc_q;
        for (int i = 0; i < PACK; i++) begin
            if (accept && (lane_q == LANE_W'(i))) begin
                acc_merged[i*M2_W +: M2_W] = in_m2;
            end
        end
    end

    // Next-state: word completion beats flush; a flush either emits now or
    // waits in flush_pend for the slot.
    always_comb begin
        lane_d       = lane_q;
        acc_d        = acc_q;
        flush_pend_d = flush_pend_q;
        out_valid_d  = out_valid_q && !out_ready;
        out_data_d   = out_data_q;
        out_cnt_d    = out_cnt_q;
        out_last_d   = out_last_q;

        if (completes) begin
            // A flush arriving with the last code just tags the full word.
            out_valid_d = 1'b1;
            out_data_d  = acc_merged;
            out_cnt_d   = CNT_W'(PACK);
            out_last_d  = flush;
            lane_d      = '0;
            acc_d       = '0;
        end else if (flush_req && slot_free) begin
            // Unused lanes are already zero because the accumulator clears
            // after every emitted word.
            out_valid_d  = 1'b1;
            out_data_d   = acc_merged;
            out_cnt_d    = fill_cnt;
            out_last_d   = 1'b1;
            lane_d       = '0;
            acc_d        = '0;
            flush_pend_d = 1'b0;
        end else begin
            acc_d        = acc_merged;
            lane_d       = lane_q + LANE_W'(accept);
            flush_pend_d = flush_req;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lane_q       <= '0;
            acc_q        <= '0;
            flush_pend_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_cnt_q    <= '0;
            out_last_q   <= 1'b0;
        end else begin
            lane_q       <= lane_d;
            acc_q        <= acc_d;
            flush_pend_q <= flush_pend_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_cnt_q    <= out_cnt_d;
            out_last_q   <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_cnt   = out_cnt_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_remap_packer.sv
// Bench for remap_packer: directed scenarios followed by random traffic, all
// compared every cycle against a queue-based model of the packing rules.
module tb_remap_packer;

    localparam int M2_W   = 15;
    localparam int PACK   = 4;
    localparam int CNT_W  = 4;
    localparam int DATA_W = M2_W * PACK;

    // ---------------- clock / reset / DUT ----------------
    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [M2_W-1:0]   in_m2;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  out_cnt;
    logic              out_last;

    always #5 clk = ~clk;

    remap_packer #(.M2_W(M2_W), .PACK(PACK), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_m2     (in_m2),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_cnt   (out_cnt),
        .out_last  (out_last)
    );

    // ---------------- reference model ----------------
    // part_q: codes accepted toward the current word.
    // exp_q : word sitting in the output register (0 or 1 entries).
    logic [M2_W-1:0]   part_q[$];
    logic [DATA_W-1:0] exp_q[$];
    logic [CNT_W-1:0]  m_cnt;
    logic              m_last;
    logic              m_pend;
    logic              m_known;

    int compared   = 0;
    int mismatched = 0;
    int dut_words  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] pack4(input int a, input int b, input int c, input int d);
        logic [DATA_W-1:0] w;
        w = DATA_W'(a) | (DATA_W'(b) << M2_W) | (DATA_W'(c) << (2*M2_W)) | (DATA_W'(d) << (3*M2_W));
        return w;
    endfunction

    // Close the current partial word into the output register.
    task automatic model_load(input logic last);
        logic [DATA_W-1:0] w;
        w = '0;
        for (int i = 0; i < part_q.size(); i++) begin
            w = w | (DATA_W'(part_q[i]) << (i * M2_W));
        end
        exp_q.push_back(w);
        m_cnt  = CNT_W'(part_q.size());
        m_last = last;
        part_q.delete();
    endtask

    // ---------------- driver: one clock cycle ----------------
    task automatic cycle(input logic r, input logic v, input logic [M2_W-1:0] d,
                         input logic fl, input logic ordy);
        logic exp_rdy;
        logic slot_free;
        logic took;
        rst_n     = r;
        in_valid  = v;
        in_m2     = d;
        flush     = fl;
        out_ready = ordy;
        #1;
        exp_rdy = r && !m_pend &&
                  ((part_q.size() < PACK - 1) || (exp_q.size() == 0) || ordy);
        chk("in_ready", in_ready, exp_rdy);
        if (m_known) begin
            chk("out_valid", out_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                chk("out_data", out_data, exp_q[0]);
                chk("out_cnt", out_cnt, m_cnt);
                chk("out_last", out_last, m_last);
            end
        end
        if (out_valid === 1'b1 && ordy) dut_words++;

        slot_free = (exp_q.size() == 0) || ordy;
        if (!r) begin
            part_q.delete();
            exp_q.delete();
            m_pend  = 1'b0;
            m_known = 1'b1;
        end else begin
            if (exp_q.size() != 0 && ordy) void'(exp_q.pop_front());
            took = v && exp_rdy;
            if (took) part_q.push_back(d);
            if (part_q.size() == PACK) begin
                model_load(fl);
            end else if (m_pend || (fl && part_q.size() > 0)) begin
                if (slot_free) begin
                    model_load(1'b1);
                    m_pend = 1'b0;
                end else begin
                    m_pend = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int w0;
        m_pend  = 1'b0;
        m_known = 1'b0;
        m_cnt   = '0;
        m_last  = 1'b0;

        // Reset
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_cnt", out_cnt, 0);
        chk("rst_out_last", out_last, 0);

        // Simple stream of four codes
        for (int i = 1; i <= 4; i++) cycle(1'b1, 1'b1, M2_W'(i), 1'b0, 1'b1);
        chk("t1_valid", out_valid, 1);
        chk("t1_data", out_data, pack4(1, 2, 3, 4));
        chk("t1_cnt", out_cnt, 4);
        chk("t1_last", out_last, 0);
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b1);

        // Twelve alternating codes at full rate -> three words
        w0 = dut_words;
        for (int i = 0; i < 12; i++)
            cycle(1'b1, 1'b1, (i % 2 == 0) ? 15'h7FFF : 15'h0000, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b1);
        chk("t2_words", dut_words - w0, 3);

        // Backpressure: eight codes with the consumer stalled
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, M2_W'(16 + i), 1'b0, 1'b0);
        chk("t3_stall", in_ready, 0);
        chk("t3_hold", out_data, pack4(16'h10, 16'h11, 16'h12, 16'h13));
        cycle(1'b1, 1'b1, 15'h17, 1'b0, 1'b1);
        chk("t3_reload_valid", out_valid, 1);
        chk("t3_word2", out_data, pack4(16'h14, 16'h15, 16'h16, 16'h17));
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b1);

        // Partial flush
        cycle(1'b1, 1'b1, 15'h0AAA, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 15'h0555, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, '0, 1'b1, 1'b1);
        chk("t4_valid", out_valid, 1);
        chk("t4_data", out_data, pack4(16'h0AAA, 16'h0555, 0, 0));
        chk("t4_cnt", out_cnt, 2);
        chk("t4_last", out_last, 1);

        // Flush with an empty accumulator (partial word drains this cycle)
        cycle(1'b1, 1'b0, '0, 1'b1, 1'b1);
        chk("t5_flush_lane0", out_valid, 0);

        // Flush coinciding with the word-completing code
        for (int i = 1; i <= 3; i++) cycle(1'b1, 1'b1, M2_W'(i + 8), 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 15'h000C, 1'b1, 1'b1);
        chk("t6_cnt", out_cnt, 4);
        chk("t6_last", out_last, 1);
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b1);
        chk("t6_no_extra", out_valid, 0);

        // Reset mid-word
        cycle(1'b1, 1'b1, 15'h0021, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 15'h0022, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 15'h0023, 1'b0, 1'b1);
        chk("t7_no_out", out_valid, 0);
        for (int i = 1; i <= 4; i++) cycle(1'b1, 1'b1, M2_W'(16'h30 + i), 1'b0, 1'b1);
        chk("t7_data", out_data, pack4(16'h31, 16'h32, 16'h33, 16'h34));
        chk("t7_cnt", out_cnt, 4);
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b1);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            cycle($urandom_range(0, 99) != 0,
                  $urandom_range(0, 3) != 0,
                  M2_W'($urandom),
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 2) != 0);
        end

        // Drain
        for (int n = 0; n < 4; n++) cycle(1'b1, 1'b0, '0, 1'b0, 1'b1);
        chk("drain_idle", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/remap_packer.md
Name: remap_packer

Overview:
- Downstream stage of the piecewise-linear remap block. It consumes the M2 codes that block produces, one code per cycle.
- Codes arrive on a valid/ready stream. The block packs PACK consecutive codes into one wide word and presents it on a registered valid/ready output.
- A flush input emits a partially filled word at frame end.
- This is the first clocked stage after the combinational remap. It decouples remap throughput from the wide-word consumer.

Parameters:
- M2_W, 15: width of one M2 code. Must equal `M2_LENGTH.
- PACK, 4: codes per output word. Legal range is 2..8.
- CNT_W, 4: width of out_cnt. Must satisfy 2^CNT_W > PACK.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  in_m2 holds a valid code
- in_ready  output  1  block accepts a code this cycle
- in_m2  input  M2_W  code from the remap stage
- flush  input  1  one-cycle pulse requesting emission of the partial word
- out_valid  output  1  output word valid
- out_ready  input  1  consumer accepts the word
- out_data  output  M2_W*PACK  packed word
- out_cnt  output  CNT_W  number of valid lanes in out_data (1..PACK)
- out_last  output  1  word closed by a flush

Behaviour:
- Reset, sampled on clk while rst_n=0:
  - out_valid=0, out_data=0, out_cnt=0, out_last=0.
  - lane counter=0, accumulator=0, flush_pend=0.
  - in_ready is forced 0 while rst_n=0.
- Reset mid-operation discards the partial word and any held output word. No emission occurs.
- Accept: a code is taken when in_valid && in_ready. It is written to accumulator bits [lane*M2_W +: M2_W]; lane 0 occupies the LSBs. The lane counter then increments.
- Output register: a single stage.
  - "slot free" = !out_valid || out_ready.
  - A word transfers when out_valid && out_ready.
- in_ready = !flush_pend && ((lane < PACK-1) || slot_free).
  - Stall occurs only when the incoming code would complete a word and the output slot is occupied.
- Word completion: a code accepted into lane PACK-1 loads the output register on the next edge with:
  - out_data = accumulator plus the new code
  - out_cnt = PACK
  - out_last = 0 (1 if flush is asserted in the same cycle)
  - Lane counter returns to 0 and the accumulator clears.
  - Latency from acceptance of the last code to out_valid=1 is 1 cycle.
- Full throughput: with out_ready=1 held, one code is accepted every cycle and one word is emitted every PACK cycles, with no bubbles.
- Flush:
  - A flush pulse with lane>0 (after counting any code accepted that cycle) sets flush_pend.
  - While flush_pend is set: when slot_free, the output register loads with:
    - the accumulator, unused lanes zero
    - out_cnt = lane
    - out_last = 1
  - The lane counter then clears and flush_pend clears. in_ready stays 0 while flush_pend=1.
- Flush edge cases:
  - Flush with lane=0 and no code accepted: ignored, no output.
  - Flush in the same cycle as a word-completing acceptance: the full word is emitted with out_last=1, and flush_pend is not set.
  - Flush while flush_pend=1: ignored.
- Output stability: while out_valid && !out_ready, out_data, out_cnt and out_last hold. out_valid cannot drop without a transfer.
- Transfer and reload in the same cycle: when out_valid && out_ready and a new word is ready that same cycle, the register reloads. out_valid stays 1 with no idle cycle.
- Arithmetic: the lane counter is $clog2(PACK) bits and never exceeds PACK-1. There is no arithmetic on code values; bits pass through unchanged.

Test Plan:
- Reset then stream: in_m2 = 0x0001, 0x0002, 0x0003, 0x0004 on consecutive cycles with out_ready=1 -> one cycle after the 4th code, out_valid=1 with:
  - lanes[0..3] = 0x0001, 0x0002, 0x0003, 0x0004
  - out_cnt=4, out_last=0
  - in_ready=1 throughout
- Continuous 12 codes 0x7FFF, 0x0000 alternating, out_ready=1 -> 3 words, each lanes = 7FFF, 0000, 7FFF, 0000, emitted every 4 cycles with no stall.
- Backpressure: 8 codes 0x10..0x17 with out_ready=0 -> in_ready drops when the 8th code is presented. Word 1 (0x10..0x13) holds stable. Raise out_ready -> word 1 transfers, word 2 (0x14..0x17) follows with no gap, and no code is lost.
- Partial flush: codes 0x0AAA, 0x0555, then flush pulse -> next cycle out_valid=1 with:
  - lanes = 0AAA, 0555, 0000, 0000
  - out_cnt=2, out_last=1
  - lane counter back to 0
- Flush corner cases:
  - flush at lane=0 -> no output.
  - flush coinciding with the 4th code -> full word with out_cnt=4, out_last=1, and no extra empty word.
- Reset mid-word: 2 codes accepted, rst_n=0 for 1 cycle -> no output; the next 4 codes form a clean word starting at lane 0.
